// File: rtl/tt_islam_ihfaz_nand_checker.sv
// tt_islam_ihfaz_nand_checker: walks {B,A}=00..11 on uio_out[1:0] and checks Y (uio_in[2]) against ~(A&B).
// Define CHECKER_INTERNAL_DUT_EN to check an internal NAND instead, with ui_in[3] as fault inject.
module tt_islam_ihfaz_nand_checker #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
  state_t state;
  logic [2:0] ui_s1, ui_s2;
  logic start_q, y_s1, y_s2, y_src, unused_ok;
  logic busy, done, pass, fail;
  logic [1:0] vec, ab;
  logic [3:0] settle_cnt, err_cnt, err_nxt;
  logic start_pulse, mismatch, fail_nxt;
`ifdef CHECKER_INTERNAL_DUT_EN
  assign y_src = ~(ab[1] & ab[0]) ^ ui_in[3];
  assign unused_ok = &{1'b0, ena, ui_in[7:4], uio_in};
`else
  assign y_src = uio_in[2];
  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in[7:3], uio_in[1:0]};
`endif
  // clear_err outranks a coincident mismatch
  always_comb begin
    start_pulse = ui_s2[0] & ~start_q;
    mismatch = (state == SAMPLE) && (y_s2 != ~(vec[1] & vec[0]));
    fail_nxt = ~ui_s2[2] & (fail | mismatch);
    err_nxt = ui_s2[2] ? 4'd0 : (mismatch && err_cnt != 4'd15) ? err_cnt + 4'd1 : err_cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ui_s1 <= '0;
      ui_s2 <= '0;
      start_q <= 1'b0;
      y_s1 <= 1'b0;
      y_s2 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      vec <= '0;
      ab <= '0;
      settle_cnt <= '0;
      err_cnt <= '0;
    end else begin
      ui_s1 <= ui_in[2:0];
      ui_s2 <= ui_s1;
      start_q <= ui_s2[0];
      y_s1 <= y_src;
      y_s2 <= y_s1;
      fail <= fail_nxt;
      err_cnt <= err_nxt;
      case (state)
        IDLE, DONE: begin
          if (start_pulse) begin
            state <= DRIVE;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
            err_cnt <= 4'd0;
            vec <= 2'd0;
          end else if (state == DONE) begin
            pass <= ~fail_nxt;
          end
        end
        DRIVE: begin
          ab <= vec;
          settle_cnt <= 4'(SETTLE_CYCLES - 1);
          state <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          state <= (settle_cnt == 4'd0) ? SAMPLE : SETTLE;
        end
        SAMPLE: begin
          if (vec != 2'd3 || ui_s2[1]) begin
            vec <= vec + 2'd1;
            state <= DRIVE;
          end else begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= ~fail_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign uo_out = {err_cnt, fail, pass, done, busy};
  assign uio_out = {6'b0, ab};
  assign uio_oe = 8'b0000_0011;
endmodule
